// File: rtl/mmp_iddmm_pkg.sv
// rtl/mmp_iddmm_pkg.sv - shared types for the IDDMM sequencer
package mmp_iddmm_pkg;

  // Wide enough for j = 0..64 at the largest legal N_MAX.
  localparam int JW = 7;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    SAVE,
    FINSUB,
    DONE
  } state_t;

  typedef struct packed {
    logic          valid;
    logic          ph;
    logic [JW-1:0] j;
    logic          qflag;
  } wb_t;

endpackage

// File: rtl/mmp_iddmm_dly.sv
// rtl/mmp_iddmm_dly.sv - DEPTH x WD shift register with flush; MSB of each entry is its valid bit
module mmp_iddmm_dly #(
  parameter int DEPTH = 8,
  parameter int WD    = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic [WD-1:0] din,
  output logic [WD-1:0] dout,
  output logic          any_valid
);

  logic [WD-1:0] sr [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
    end else if (flush) begin
      for (int k = 0; k < DEPTH; k++) sr[k] <= '0;
    end else begin
      sr[0] <= din;
      for (int k = 1; k < DEPTH; k++) sr[k] <= sr[k-1];
    end
  end

  assign dout = sr[DEPTH-1];

  always_comb begin
    any_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) any_valid = any_valid | sr[k][WD-1];
  end

endmodule

// File: rtl/mmp_iddmm_seq.sv
// rtl/mmp_iddmm_seq.sv - IDDMM PE-array sequencer: (i, j) issue walk, PE strobes,
// delayed accumulator write-back and final-subtraction handshake
module mmp_iddmm_seq
  import mmp_iddmm_pkg::*;
#(
  parameter int N_MAX    = 32,
  parameter int AW       = $clog2(N_MAX),
  parameter int PIPE_LAT = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          task_req,
  input  logic [AW:0]   cfg_words,
  input  logic          cfg_half,
  input  logic          abort,
  output logic          task_ack,
  output logic          task_err,
  output logic          task_done,
  output logic          busy,
  output logic          ctl_carry_clr,
  output logic          ctl_carry_ena,
  output logic          ctl_carry_sel,
  output logic          ctl_c_pre_clr,
  output logic          ctl_c_pre_ena,
  output logic          ctl_q_ena,
  input  logic          carry,
  output logic          comp_req,
  input  logic          comp_end,
  output logic          ref_an,
  output logic [AW:0]   rd_addr_x,
  output logic [AW-1:0] rd_addr_y,
  output logic [AW-1:0] rd_addr_m,
  output logic [AW-1:0] rd_addr_a,
  output logic [AW-1:0] wr_a_addr,
  output logic          wr_a_ena
);

  state_t        state;
  logic [AW:0]   n_r;
  logic [AW:0]   j_r;
  logic [AW-1:0] i_r;
  logic          half_r;
  logic          q_r;
  logic          ph_r;
  logic          started;
  logic          issuing;
  logic          slot_end;
  logic          row_end;
  logic          last_row;
  logic          cfg_ok;
  logic          any_valid;
  wb_t           wb_in;
  wb_t           wb_out;

  assign cfg_ok    = (cfg_words != '0) && (int'(cfg_words) <= N_MAX);
  // ISSUE's first cycle is a dead cycle so issue starts one cycle after task_ack.
  assign issuing   = (state == ISSUE) && started;
  assign slot_end  = !half_r || ph_r;
  assign row_end   = !q_r && (j_r == n_r);
  assign last_row  = ({1'b0, i_r} == (n_r - 1'b1));
  assign busy      = (state != IDLE);

  assign rd_addr_x = j_r;
  assign rd_addr_y = i_r;
  assign rd_addr_m = j_r[AW-1:0];
  assign rd_addr_a = j_r[AW-1:0];

  always_comb begin
    wb_in       = '0;
    wb_in.valid = issuing;
    wb_in.ph    = ph_r;
    wb_in.j     = JW'(j_r);
    wb_in.qflag = q_r;
  end

  mmp_iddmm_dly #(
    .DEPTH (PIPE_LAT),
    .WD    ($bits(wb_t))
  ) u_dly (
    .clk       (clk),
    .rst       (rst),
    .flush     (abort),
    .din       (wb_in),
    .dout      (wb_out),
    .any_valid (any_valid)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      n_r           <= '0;
      j_r           <= '0;
      i_r           <= '0;
      half_r        <= 1'b0;
      q_r           <= 1'b0;
      ph_r          <= 1'b0;
      started       <= 1'b0;
      task_ack      <= 1'b0;
      task_err      <= 1'b0;
      task_done     <= 1'b0;
      ctl_carry_clr <= 1'b0;
      ctl_carry_ena <= 1'b0;
      ctl_carry_sel <= 1'b0;
      ctl_c_pre_clr <= 1'b0;
      ctl_c_pre_ena <= 1'b0;
      ctl_q_ena     <= 1'b0;
      comp_req      <= 1'b0;
      ref_an        <= 1'b0;
      wr_a_addr     <= '0;
      wr_a_ena      <= 1'b0;
    end else begin
      task_ack      <= 1'b0;
      task_err      <= 1'b0;
      task_done     <= 1'b0;
      ctl_q_ena     <= issuing && q_r;
      ctl_c_pre_clr <= issuing && q_r;
      ctl_carry_clr <= issuing && (i_r == '0) && (j_r == '0);
      ctl_carry_sel <= issuing && row_end;
      ctl_carry_ena <= issuing && row_end && slot_end;
      ctl_c_pre_ena <= issuing && half_r && ph_r;
      // Data slot j writes word j-1; the Q slot and j=0 carry no result.
      wr_a_ena      <= wb_out.valid && (wb_out.j != '0) && !wb_out.qflag && (!half_r || wb_out.ph);
      wr_a_addr     <= AW'(wb_out.j - 1'b1);

      if (abort) begin
        state         <= IDLE;
        started       <= 1'b0;
        ph_r          <= 1'b0;
        comp_req      <= 1'b0;
        ctl_q_ena     <= 1'b0;
        ctl_c_pre_clr <= 1'b0;
        ctl_carry_clr <= 1'b0;
        ctl_carry_sel <= 1'b0;
        ctl_carry_ena <= 1'b0;
        ctl_c_pre_ena <= 1'b0;
        wr_a_ena      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (task_req) begin
              if (cfg_ok) begin
                task_ack <= 1'b1;
                n_r      <= cfg_words;
                half_r   <= cfg_half;
                i_r      <= '0;
                j_r      <= '0;
                q_r      <= 1'b1;
                ph_r     <= 1'b0;
                started  <= 1'b0;
                state    <= ISSUE;
              end else begin
                task_err <= 1'b1;
              end
            end
          end
          ISSUE: begin
            started <= 1'b1;
            if (started) begin
              if (half_r) ph_r <= ~ph_r;
              if (slot_end) begin
                if (q_r) begin
                  q_r <= 1'b0;
                end else if (row_end) begin
                  if (last_row) begin
                    state   <= DRAIN;
                    started <= 1'b0;
                    i_r     <= '0;
                    j_r     <= '0;
                  end else begin
                    i_r <= i_r + 1'b1;
                    j_r <= '0;
                    q_r <= 1'b1;
                  end
                end else begin
                  j_r <= j_r + 1'b1;
                end
              end
            end
          end
          DRAIN: begin
            if (!any_valid) state <= SAVE;
          end
          SAVE: begin
            ref_an   <= carry;
            comp_req <= 1'b1;
            state    <= FINSUB;
          end
          FINSUB: begin
            if (comp_end) begin
              comp_req  <= 1'b0;
              task_done <= 1'b1;
              state     <= DONE;
            end
          end
          DONE: begin
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mmp_iddmm_seq.sv
// tb/tb_mmp_iddmm_seq.sv - randomized scoreboard bench for mmp_iddmm_seq
module tb_mmp_iddmm_seq;

  localparam int N_MAX = 32;
  localparam int AW    = $clog2(N_MAX);
  localparam int PL    = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          task_req;
  logic [AW:0]   cfg_words;
  logic          cfg_half;
  logic          abort;
  logic          task_ack, task_err, task_done, busy;
  logic          ctl_carry_clr, ctl_carry_ena, ctl_carry_sel;
  logic          ctl_c_pre_clr, ctl_c_pre_ena, ctl_q_ena;
  logic          carry;
  logic          comp_req;
  logic          comp_end;
  logic          ce_resp, ce_stim;
  logic          ref_an;
  logic [AW:0]   rd_addr_x;
  logic [AW-1:0] rd_addr_y, rd_addr_m, rd_addr_a, wr_a_addr;
  logic          wr_a_ena;

  assign comp_end = ce_resp | ce_stim;

  always #5 clk = ~clk;

  mmp_iddmm_seq #(.N_MAX(N_MAX), .AW(AW), .PIPE_LAT(PL)) dut (
    .clk(clk), .rst(rst), .task_req(task_req), .cfg_words(cfg_words), .cfg_half(cfg_half),
    .abort(abort), .task_ack(task_ack), .task_err(task_err), .task_done(task_done), .busy(busy),
    .ctl_carry_clr(ctl_carry_clr), .ctl_carry_ena(ctl_carry_ena), .ctl_carry_sel(ctl_carry_sel),
    .ctl_c_pre_clr(ctl_c_pre_clr), .ctl_c_pre_ena(ctl_c_pre_ena), .ctl_q_ena(ctl_q_ena),
    .carry(carry), .comp_req(comp_req), .comp_end(comp_end), .ref_an(ref_an),
    .rd_addr_x(rd_addr_x), .rd_addr_y(rd_addr_y), .rd_addr_m(rd_addr_m), .rd_addr_a(rd_addr_a),
    .wr_a_addr(wr_a_addr), .wr_a_ena(wr_a_ena)
  );

  typedef struct {
    int n;
    bit half;
    bit carry;
  } exp_task_t;

  exp_task_t exp_task[$];
  int        exp_wr[$];

  int  tests = 0, fails = 0;
  int  cyc = 0;
  int  to_cnt = 0, exp_err = 0;
  bit  wr_dc = 1'b0, end_req = 1'b0, end_done = 1'b0;

  int  ack_cyc = 0, first_strobe = -1, last_cena = 0, cena_cnt = 0, sel_cnt = 0, cpe_cnt = 0;
  int  wr_cnt = 0, last_wr = 0, consec_wr = 0, cena_noph = 0, creq_cyc = 0, ce_cyc = 0;
  int  max_x = 0, max_y = 0, err_seen = 0, strobe_viol = 0;
  bit  prev_wr = 1'b0, prev_creq = 1'b0, abort_prev = 1'b0;
  logic any_strobe;
  logic [12+AW+1+4*AW:0] outs;
  exp_task_t e_mon;

  assign any_strobe = ctl_carry_clr | ctl_carry_ena | ctl_carry_sel | ctl_c_pre_clr | ctl_c_pre_ena | ctl_q_ena;
  assign outs = {task_ack, task_err, task_done, busy, ctl_carry_clr, ctl_carry_ena, ctl_carry_sel,
                 ctl_c_pre_clr, ctl_c_pre_ena, ctl_q_ena, comp_req, ref_an, wr_a_ena,
                 rd_addr_x, rd_addr_y, rd_addr_m, rd_addr_a, wr_a_addr};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: observes the DUT at the falling edge and settles every expectation.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_outputs_zero", longint'(outs), 0);
      prev_wr = 1'b0; prev_creq = 1'b0; abort_prev = 1'b0;
    end else begin
      if (abort_prev)
        chk("abort_next_idle", longint'({busy, any_strobe, wr_a_ena, comp_req, task_done}), 0);
      if (task_ack) begin
        ack_cyc = cyc; first_strobe = -1; last_cena = 0; cena_cnt = 0; sel_cnt = 0; cpe_cnt = 0;
        wr_cnt = 0; last_wr = 0; consec_wr = 0; cena_noph = 0; creq_cyc = 0; ce_cyc = 0;
        max_x = 0; max_y = 0;
      end
      if (any_strobe) begin
        if (first_strobe < 0) first_strobe = cyc;
        if (!busy) strobe_viol++;
      end
      if (ctl_carry_ena) begin
        last_cena = cyc; cena_cnt++;
        if (!ctl_c_pre_ena) cena_noph++;
      end
      if (ctl_carry_sel) sel_cnt++;
      if (ctl_c_pre_ena) cpe_cnt++;
      if (busy) begin
        if (int'(rd_addr_x) > max_x) max_x = int'(rd_addr_x);
        if (int'(rd_addr_y) > max_y) max_y = int'(rd_addr_y);
      end
      if (wr_a_ena) begin
        wr_cnt++; last_wr = cyc;
        if (prev_wr) consec_wr++;
        if (!wr_dc) begin
          if (exp_wr.size() == 0) chk("wr_unexpected", 1, 0);
          else chk("wr_addr", wr_a_addr, exp_wr.pop_front());
        end
      end
      prev_wr = wr_a_ena;
      if (comp_req && !prev_creq) creq_cyc = cyc;
      prev_creq = comp_req;
      if (comp_end && comp_req) ce_cyc = cyc;
      if (task_err) begin
        err_seen++;
        chk("err_busy", busy, 0);
      end
      if (task_done) begin
        if (exp_task.size() == 0) chk("done_unexpected", 1, 0);
        else begin
          e_mon = exp_task.pop_front();
          chk("ref_an", ref_an, e_mon.carry);
          chk("comp_req_at_done", comp_req, 0);
          chk("ack_to_first_strobe", first_strobe - ack_cyc, 2);
          chk("issue_len", last_cena - first_strobe + 1, e_mon.n * (e_mon.n + 2) * (e_mon.half ? 2 : 1));
          chk("wr_count", wr_cnt, e_mon.n * e_mon.n);
          chk("last_wr_latency", last_wr - last_cena, PL);
          chk("carry_ena_count", cena_cnt, e_mon.n);
          chk("carry_sel_count", sel_cnt, e_mon.half ? 2 * e_mon.n : e_mon.n);
          chk("c_pre_ena_count", cpe_cnt, e_mon.half ? e_mon.n * (e_mon.n + 2) : 0);
          if (e_mon.half) begin
            chk("half_wr_width", consec_wr, 0);
            chk("carry_ena_on_ph1", cena_noph, 0);
          end
          chk("comp_req_after_drain", longint'(creq_cyc > last_wr), 1);
          chk("done_after_comp_end", cyc - ce_cyc, 1);
          chk("max_rd_addr_x", max_x, e_mon.n);
          chk("max_rd_addr_y", max_y, e_mon.n - 1);
        end
      end
      abort_prev = abort;
    end
    if (end_req && !end_done) begin
      chk("exp_wr_left", exp_wr.size(), 0);
      chk("exp_task_left", exp_task.size(), 0);
      chk("task_err_count", err_seen, exp_err);
      chk("strobe_while_idle", strobe_viol, 0);
      chk("timeouts", to_cnt, 0);
      end_done = 1'b1;
    end
  end

  // Final-subtraction responder: comp_end five cycles after comp_req rises.
  initial begin
    int  cnt;
    bit  creq_d;
    cnt = 0; creq_d = 1'b0; ce_resp = 1'b0;
    forever begin
      @(posedge clk); #1;
      ce_resp = 1'b0;
      if (rst) begin
        cnt = 0;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) ce_resp = 1'b1;
      end else if (comp_req && !creq_d) begin
        cnt = 5;
      end
      creq_d = comp_req;
    end
  end

  task automatic run_task(input int n, input bit h, input bit c);
    exp_task_t e;
    bit seen;
    e.n = n; e.half = h; e.carry = c;
    exp_task.push_back(e);
    for (int r = 0; r < n; r++)
      for (int a = 0; a < n; a++) exp_wr.push_back(a);
    @(posedge clk); #1;
    cfg_words = n[AW:0]; cfg_half = h; carry = c; task_req = 1'b1;
    @(posedge clk); #1;
    task_req = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20000; k++) begin
      @(posedge clk); #2;
      if (task_done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) to_cnt++;
    repeat (2) @(posedge clk);
  endtask

  task automatic run_reject(input int w);
    @(posedge clk); #1;
    cfg_words = w[AW:0]; cfg_half = 1'b0; task_req = 1'b1;
    exp_err++;
    @(posedge clk); #1;
    task_req = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic run_abort(input int n);
    @(posedge clk); #1;
    cfg_words = n[AW:0]; cfg_half = 1'b0; task_req = 1'b1;
    @(posedge clk); #1;
    task_req = 1'b0;
    if (!task_ack) to_cnt++;
    repeat (11) @(posedge clk);
    #1;
    abort = 1'b1; ce_stim = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0; ce_stim = 1'b0;
    repeat (PL + 6) @(posedge clk);
  endtask

  task automatic run_reset(input int n);
    wr_dc = 1'b1;
    @(posedge clk); #1;
    cfg_words = n[AW:0]; cfg_half = 1'b0; task_req = 1'b1;
    @(posedge clk); #1;
    task_req = 1'b0;
    repeat (12) @(posedge clk);
    #2;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    wr_dc = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; task_req = 1'b0; cfg_words = '0; cfg_half = 1'b0;
    abort = 1'b0; carry = 1'b0; ce_stim = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);

    run_task(4, 1'b0, 1'($urandom_range(0, 1)));
    run_task(4, 1'b1, 1'($urandom_range(0, 1)));
    run_task(1, 1'b0, 1'b0);
    run_task(1, 1'b1, 1'b1);
    run_task(N_MAX, 1'b0, 1'b1);
    run_reset(2);
    run_reject(0);
    run_reject(N_MAX + 1);
    run_abort(4);
    run_task(3, 1'b0, 1'b1);
    for (int t = 0; t < 6; t++)
      run_task($urandom_range(1, 8), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    end_req = 1'b1;
    for (int k = 0; k < 10 && !end_done; k++) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mmp_iddmm_seq.md
# mmp_iddmm_seq

Parametrised sequencer for the IDDMM Montgomery multiplier PE array, generalising the fixed 32-word controller. It walks the (i, j) word-iteration space for an operand size chosen per task (1..N_MAX words), in full-rate or half-rate issue mode, and drives the PE pipeline strobes. It also drives the operand/modulus/accumulator read addresses, the delayed accumulator write-back and the final-subtraction handshake. It sits between the RSA task scheduler and the PE/SUB/RAM datapath, and adds task ack/done/abort/error signalling.

## Interface
- N_MAX, 32: maximum operand words; legal range 2..64.
- AW, $clog2(N_MAX): word address width.
- PIPE_LAT, 8: PE latency from strobe to result, in cycles (L1+L2+L3+L4); ≥1.
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- task_req  in  1  start request; sampled only in IDLE.
- cfg_words  in  AW+1  operand word count n; captured on accept.
- cfg_half  in  1  1 = half-rate issue, each slot held 2 cycles; captured on accept.
- abort  in  1  synchronous abort; effective in any state.
- task_ack  out  1  1-cycle pulse on accept.
- task_err  out  1  1-cycle pulse when the request is rejected.
- task_done  out  1  1-cycle pulse on completion.
- busy  out  1  high in every state except IDLE.
- ctl_carry_clr, ctl_carry_ena, ctl_carry_sel, ctl_c_pre_clr, ctl_c_pre_ena, ctl_q_ena  out  1 each  PE strobes.
- carry  in  1  PE final carry.
- comp_req  out  1  final-subtraction request.
- comp_end  in  1  final-subtraction done pulse.
- ref_an  out  1  latched final carry.
- rd_addr_x  out  AW+1  X word address (j, 0..n).
- rd_addr_y  out  AW  Y word address (i).
- rd_addr_m  out  AW  M word address (j).
- rd_addr_a  out  AW  A word address (j).
- wr_a_addr  out  AW  accumulator write address.
- wr_a_ena  out  1  accumulator write enable.
- Reset value of every output is 0.

## Operation
- **Request check.** In IDLE, task_req with 1 ≤ cfg_words ≤ N_MAX gives task_ack the next cycle and a move to ISSUE. Any other cfg_words gives task_err the next cycle and the block stays in IDLE.
- **Issue space.** Rows i = 0..n-1. Each row is one Q slot (j=0, q flag set) followed by data slots j = 0..n, so a row is n+2 slots.
- **Slot length.** A slot is 1 cycle in full-rate mode. In half-rate mode it is 2 cycles, with phase ph = 0 then 1; counters advance only on ph=1.
- **Read addresses.** rd_addr_* come combinationally from the current issue counters: x/m/a = j, y = i.
- **Registered strobes.** All strobes are registered and lag the issue cycle by 1 (1-cycle RAM latency):
  - ctl_q_ena = ctl_c_pre_clr = Q slot.
  - ctl_carry_clr = i==0 && j==0, covering both the Q slot and data slot 0.
  - ctl_carry_sel = j==n.
  - ctl_carry_ena = j==n, qualified by ph=1 in half mode.
  - ctl_c_pre_ena = ph (0 in full mode).
- **Write-back.** The tuple {valid, ph, j, qflag} goes through a PIPE_LAT-deep delay line. At the output, wr_a_ena = valid && j≠0 && !qflag && (full mode || ph=1), and wr_a_addr = (j-1)[AW-1:0]. This gives exactly n writes per row, to addresses 0..n-1 in ascending order.
- **States.**
  - IDLE → ISSUE on accept.
  - ISSUE → DRAIN after the last slot of row n-1 issues.
  - DRAIN → SAVE when the delay line holds no valid entry.
  - SAVE: ref_an ← carry and comp_req ← 1, for 1 cycle, → FINSUB.
  - FINSUB: when comp_end arrives, comp_req ← 0 and → DONE.
  - DONE: task_done pulses, → IDLE.
- **Abort.** abort in any non-IDLE state moves to IDLE next cycle and clears the delay-line valid bits, comp_req and all strobes. ref_an holds. No task_done is given.
- **Abort priority.** abort has priority over comp_end and task_req in the same cycle.
- **Reset.** rst mid-task does the same as abort, asynchronously, and also clears ref_an.
- **comp_end outside FINSUB** is ignored.
- **ref_an** holds its value until the next SAVE.

## Timing
- **Issue length.** n·(n+2) cycles in full mode, 2·n·(n+2) cycles in half mode.
- **First issue.** The first issue cycle is 1 cycle after task_ack; the first strobe is 1 cycle after that.
- **Last write.** The last wr_a_ena comes PIPE_LAT+1 cycles after the last data slot issues.
- **Request to done.** From accept to task_done: issue length + PIPE_LAT + 1 (drain) + 1 (SAVE) + comp_end wait + 1.
- **Row gap.** There are no idle cycles between rows; the Q slot itself is the row gap.
- **Back-to-back tasks.** task_req held high re-accepts on the first cycle the block is back in IDLE after task_done.

## Structure
- Package mmp_iddmm_pkg holds the state enum (IDLE, ISSUE, DRAIN, SAVE, FINSUB, DONE) and the delay-line tuple struct.
- Sub-module mmp_iddmm_dly: a parametrised PIPE_LAT × WD shift register with a synchronous flush input and an any_valid output.

## Test plan
- **Full-rate, n=4, PIPE_LAT=8:** 24 issue cycles; wr_a_ena pulses 16 times with addresses 0,1,2,3 repeated 4 times; comp_req rises after DRAIN; comp_end 5 cycles later → task_done.
- **Half-rate, n=4:** 48 issue cycles; ctl_c_pre_ena toggles every cycle; still exactly 16 writes, each 1 cycle wide; ctl_carry_ena high only on the ph=1 cycle of j=4.
- **n=N_MAX=32, carry=1 at SAVE:** ref_an=1; last wr_a_addr=31; rd_addr_x reaches 32.
- **Rejected requests:** cfg_words=0 and cfg_words=33 → task_err, busy stays 0, no strobes.
- **Abort at issue cycle 10, with comp_end in the same cycle:** next cycle IDLE, no wr_a_ena afterwards, no task_done; a new task then completes normally.
- **Async rst mid-DRAIN:** all outputs go to 0 immediately, including ref_an.
